// File: rtl/seq_pp_multiplier.sv
// seq_pp_multiplier: sequential shift-and-add multiplier, unsigned or two's-complement.
// The operands are converted to sign and magnitude when they are accepted. One
// partial-product row is added per clock, and the sign is applied to the final sum.
//
// Ports:
//   clk, rst_n   clock (rising edge) and async active-low reset
//   in_valid     operand handshake, input side; in_ready is high only in IDLE
//   a, b         multiplicand and multiplier, WIDTH bits each
//   signed_mode  1: a and b are two's complement; latched on acceptance
//   out_valid    result handshake, output side; out_ready is the consumer's acknowledge
//   product      2*WIDTH-bit exact result, held while out_valid=1
//   busy         high in RUN and in DONE
module seq_pp_multiplier #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned EARLY_EXIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;     // multiplicand magnitude, pre-shifted to the current row
  logic [WIDTH-1:0] r_mb;        // remaining multiplier bits, LSB is the current row
  logic             r_neg;
  logic [PW-1:0]    r_product;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [PW-1:0]    w_acc_next;
  logic [PW-1:0]    w_result;
  logic             w_last;

  // Sign/magnitude split. The magnitude of -2^(WIDTH-1) still fits in WIDTH unsigned bits.
  assign w_a_neg = signed_mode & a[WIDTH-1];
  assign w_b_neg = signed_mode & b[WIDTH-1];
  assign w_ma    = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_mb    = w_b_neg ? (~b + WIDTH'(1)) : b;

  // Add the current partial-product row. Stop on the last row, or, with early exit,
  // stop once no set multiplier bits remain above the current row.
  assign w_acc_next = r_mb[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last     = (r_cnt == LAST_CNT) ||
                      ((EARLY_EXIT != 0) && (r_mb[WIDTH-1:1] == '0));
  // Negate only a non-zero sum, so a zero result never carries a sign.
  assign w_result   = (r_neg && (w_acc_next != '0)) ? (~w_acc_next + PW'(1)) : w_acc_next;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mb        <= '0;
      r_neg       <= 1'b0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand    <= {WIDTH'(0), w_ma};
            r_mb       <= w_mb;
            r_neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mb    <= r_mb >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_product   <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_pp_multiplier.sv
// Testbench for seq_pp_multiplier. WIDTH=4 throughout. One instance is built without
// early exit and one with early exit; each is checked against an integer reference model.
module tb_seq_pp_multiplier;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic clk;
  logic rst_n;

  logic          iv0, ir0, sm0, ov0, or0, busy0;
  logic [W-1:0]  a0, b0;
  logic [PW-1:0] p0;
  logic          iv1, ir1, sm1, ov1, or1, busy1;
  logic [W-1:0]  a1, b1;
  logic [PW-1:0] p1;

  int n_tests;
  int n_fail;

  seq_pp_multiplier #(.WIDTH(W), .EARLY_EXIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .signed_mode(sm0), .out_valid(ov0), .out_ready(or0), .product(p0), .busy(busy0)
  );

  seq_pp_multiplier #(.WIDTH(W), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .signed_mode(sm1), .out_valid(ov1), .out_ready(or1), .product(p1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the exact integer product of the operand values, truncated to 2*W bits.
  function automatic logic [PW-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input bit sm);
    longint vx, vy;
    vx = (sm && x[W-1]) ? longint'(x) - (longint'(1) << W) : longint'(x);
    vy = (sm && y[W-1]) ? longint'(y) - (longint'(1) << W) : longint'(y);
    return PW'(vx * vy);
  endfunction

  // Reference latency in edges after acceptance.
  function automatic int ref_latency(input bit ee, input logic [W-1:0] y, input bit sm);
    int mag, hi;
    if (!ee) return W;
    mag = (sm && y[W-1]) ? (1 << W) - int'(y) : int'(y);
    hi  = 0;
    for (int i = 0; i < W; i++) if (((mag >> i) & 1) != 0) hi = i + 1;
    return (hi < 1) ? 1 : hi;
  endfunction

  task automatic drive_in(input bit ee, input bit v, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input bit sm);
    if (ee) begin iv1 = v; a1 = ta; b1 = tb; sm1 = sm; end
    else    begin iv0 = v; a0 = ta; b0 = tb; sm0 = sm; end
  endtask

  task automatic set_oready(input bit ee, input bit r);
    if (ee) or1 = r; else or0 = r;
  endtask

  function automatic bit get_ov(input bit ee);
    return ee ? ov1 : ov0;
  endfunction

  function automatic logic [PW-1:0] get_p(input bit ee);
    return ee ? p1 : p0;
  endfunction

  // Present one operand pair for a single edge and wait for out_valid.
  // The caller must be 1 time unit after a rising edge, with in_ready high.
  task automatic do_op(input bit ee, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input bit sm, output logic [PW-1:0] p, output int lat);
    bit timeout;
    drive_in(ee, 1'b1, ta, tb, sm);
    @(posedge clk); #1;
    drive_in(ee, 1'b0, ta, tb, sm);
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 3 * W + 5; i++) begin
      if (get_ov(ee)) begin timeout = 1'b0; break; end
      @(posedge clk); #1;
      lat++;
    end
    p = get_p(ee);
    if (timeout) begin
      n_tests++;
      n_fail++;
      $display("FAIL op_timeout: ee=%0d a=%h b=%h no out_valid after %0d edges", ee, ta, tb, lat);
    end
  endtask

  task automatic drain(input bit ee);
    set_oready(ee, 1'b1);
    @(posedge clk); #1;
    set_oready(ee, 1'b0);
  endtask

  // Run one operation and compare its product and latency with the reference.
  task automatic check_op(input string name, input bit ee, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input bit sm);
    logic [PW-1:0] p, exp_p;
    int lat, exp_lat;
    do_op(ee, ta, tb, sm, p, lat);
    exp_p   = ref_product(ta, tb, sm);
    exp_lat = ref_latency(ee, tb, sm);
    n_tests++;
    if (p !== exp_p) begin
      n_fail++;
      $display("FAIL %s_product: a=%h b=%h sm=%0d got %h expected %h", name, ta, tb, sm, p, exp_p);
    end
    n_tests++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: a=%h b=%h sm=%0d got %0d expected %0d", name, ta, tb, sm, lat, exp_lat);
    end
    drain(ee);
    n_tests++;
    if ((ee ? ir1 : ir0) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_after_drain: got %b expected 1", name, (ee ? ir1 : ir0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_in(1'b0, 1'b0, '0, '0, 1'b0);
    drive_in(1'b1, 1'b0, '0, '0, 1'b0);
    or0 = 1'b0; or1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({ov0, busy0, ov1, busy1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {ov0, busy0, ov1, busy1});
    end
    n_tests++;
    if ({p0, p1} !== '0) begin
      n_fail++;
      $display("FAIL reset_product: got %h %h expected 0", p0, p1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({ir0, ir1, ov0, ov1, busy0, busy1} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 110000", {ir0, ir1, ov0, ov1, busy0, busy1});
    end
  endtask

  task automatic test_directed();
    check_op("t1_unsigned_3x3", 1'b0, 4'd3, 4'd3, 1'b0);
    check_op("t2_signed_m8xm8", 1'b0, 4'h8, 4'h8, 1'b1);
    check_op("t2_signed_m3x5",  1'b0, 4'hD, 4'h5, 1'b1);
    check_op("t3_unsigned_max", 1'b0, 4'hF, 4'hF, 1'b0);
    check_op("zero_signed",     1'b0, 4'h0, 4'hB, 1'b1);
    check_op("signed_m1xm1",    1'b0, 4'hF, 4'hF, 1'b1);
  endtask

  task automatic test_early_exit();
    check_op("t5_b1",        1'b1, 4'd7, 4'd1, 1'b0);
    check_op("t5_b0",        1'b1, 4'd9, 4'd0, 1'b0);
    check_op("t5_b8",        1'b1, 4'd5, 4'h8, 1'b0);
    check_op("ee_signed_m8", 1'b1, 4'd3, 4'h8, 1'b1);
    check_op("ee_signed_m1", 1'b1, 4'hA, 4'hF, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  ta, tb;
    logic [PW-1:0] p, exp_p;
    int lat;
    ta = W'($urandom_range(1, 15));
    tb = W'($urandom_range(1, 15));
    exp_p = ref_product(ta, tb, 1'b1);
    do_op(1'b0, ta, tb, 1'b1, p, lat);
    n_tests++;
    if (p !== exp_p) begin
      n_fail++;
      $display("FAIL bp_product: got %h expected %h", p, exp_p);
    end
    // New operands offered while DONE must be ignored.
    drive_in(1'b0, 1'b1, ~ta, ~tb, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({ov0, ir0, busy0} !== 3'b101 || p0 !== exp_p) begin
        n_fail++;
        $display("FAIL bp_hold_cycle%0d: ov/ir/busy=%b product=%h expected 101 %h",
                 i, {ov0, ir0, busy0}, p0, exp_p);
      end
    end
    drive_in(1'b0, 1'b0, ta, tb, 1'b0);
    drain(1'b0);
    n_tests++;
    if ({ov0, ir0, busy0} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_release: ov/ir/busy=%b expected 010", {ov0, ir0, busy0});
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_accept: busy=%b expected 0", busy0);
    end
  endtask

  // out_ready held high from the start: the result is still presented, for exactly one cycle.
  task automatic test_early_ready();
    logic [PW-1:0] p;
    int lat;
    set_oready(1'b0, 1'b1);
    do_op(1'b0, 4'd6, 4'd5, 1'b0, p, lat);
    n_tests++;
    if (p !== 8'd30 || lat != 4) begin
      n_fail++;
      $display("FAIL early_ready: product=%h lat=%0d expected 1e 4", p, lat);
    end
    @(posedge clk); #1;
    set_oready(1'b0, 1'b0);
    n_tests++;
    if ({ov0, ir0} !== 2'b01) begin
      n_fail++;
      $display("FAIL early_ready_handshake: ov/ir=%b expected 01", {ov0, ir0});
    end
  endtask

  // All operand pairs in both modes, in a random order.
  task automatic test_sweep();
    int order[512];
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      check_op("sweep", 1'b0, W'(order[i] & 15), W'((order[i] >> 4) & 15), order[i][8]);
    end
  endtask

  task automatic test_back_to_back_ee();
    for (int i = 0; i < 200; i++) begin
      check_op("ee_rand", 1'b1, W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_run();
    drive_in(1'b0, 1'b1, 4'd5, 4'd6, 1'b0);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b0, 4'd5, 4'd6, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ov0, busy0} !== 2'b00 || p0 !== '0) begin
      n_fail++;
      $display("FAIL t6_reset_async: ov/busy=%b product=%h expected 00 00", {ov0, busy0}, p0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({ir0, busy0} !== 2'b10) begin
      n_fail++;
      $display("FAIL t6_idle_after_reset: ir/busy=%b expected 10", {ir0, busy0});
    end
    check_op("t6_after_reset", 1'b0, 4'd2, 4'd7, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_early_exit();
    test_backpressure();
    test_early_ready();
    test_sweep();
    test_back_to_back_ee();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
